// File: rtl/fwd_hazard_scoreboard.sv
// ============================================================================
//  Module      : fwd_hazard_scoreboard
//  Description : EXE-stage operand forwarding with youngest-first stage
//                priority, load-use stall and a long-latency write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif

module fwd_hazard_scoreboard #(
    parameter int NUM_RS  = 2,
    parameter int NUM_STG = 2,
    parameter int XLEN    = `GPR_WIDTH,
    parameter int AW      = `GPR_ADDR_SPACE,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RS*AW-1:0]    rs_addr,
    input  logic [NUM_RS-1:0]       rs_re,
    input  logic [NUM_STG*AW-1:0]   stg_rd_addr,
    input  logic [NUM_STG-1:0]      stg_rd_we,
    input  logic [NUM_STG-1:0]      stg_rd_rdy,
    input  logic [NUM_STG*XLEN-1:0] stg_rd_val,
    input  logic [AW-1:0]           dec_rd_addr,
    input  logic                    dec_rd_we,
    input  logic                    lop_issue,
    input  logic [AW-1:0]           lop_issue_rd,
    input  logic                    lop_done,
    input  logic [AW-1:0]           lop_done_rd,
    input  logic [XLEN-1:0]         lop_done_val,
    output logic [NUM_RS*XLEN-1:0]  fwd_val,
    output logic [NUM_RS-1:0]       fwd_we,
    output logic                    stall,
    output logic                    sb_full,
    output logic                    sb_err,
    output logic [31:0]             stall_cnt
);

    localparam int                c_num_reg = 1 << AW;
    localparam int                c_cw      = $clog2(MAX_OUT + 1);
    localparam logic [c_cw-1:0]   c_max     = c_cw'(MAX_OUT);
    localparam logic [c_cw-1:0]   c_one     = c_cw'(1);
    localparam logic [AW-1:0]     c_x0      = '0;

    logic [c_num_reg-1:1]   r_busy;
    logic [c_cw-1:0]        r_count;
    logic                   r_sb_err;
    logic [31:0]            r_stall_cnt;

    logic [c_num_reg-1:0]   w_busy;
    logic                   w_full;
    logic [NUM_RS-1:0]      w_found;
    logic [NUM_RS-1:0]      w_sel_rdy;
    logic [XLEN-1:0]        w_sel_val [NUM_RS];
    logic [NUM_RS-1:0]      w_port_haz;
    logic [NUM_RS-1:0]      w_fwd_we;
    logic [NUM_RS*XLEN-1:0] w_fwd_val;
    logic                   w_waw;
    logic                   w_stall;

    assign w_busy = {r_busy, 1'b0};
    assign w_full = (r_count == c_max);

    // Walk oldest to youngest so a younger hit overrides any older one.
    always_comb begin
        w_found   = '0;
        w_sel_rdy = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_sel_val[i] = '0;
            for (int s = NUM_STG - 1; s >= 0; s--) begin
                if (rs_re[i] && stg_rd_we[s] &&
                    (stg_rd_addr[s*AW +: AW] == rs_addr[i*AW +: AW]) &&
                    (rs_addr[i*AW +: AW] != c_x0)) begin
                    w_found[i]   = 1'b1;
                    w_sel_rdy[i] = stg_rd_rdy[s];
                    w_sel_val[i] = stg_rd_val[s*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_fwd_we   = '0;
        w_fwd_val  = '0;
        w_port_haz = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_re[i] && (rs_addr[i*AW +: AW] != c_x0)) begin
                if (w_found[i]) begin
                    if (w_sel_rdy[i]) begin
                        w_fwd_we[i]                = 1'b1;
                        w_fwd_val[i*XLEN +: XLEN]  = w_sel_val[i];
                    end else begin
                        w_port_haz[i] = 1'b1;
                    end
                end else if (w_busy[rs_addr[i*AW +: AW]]) begin
                    // Result returning this cycle is bypassed instead of stalling.
                    if (lop_done && (lop_done_rd == rs_addr[i*AW +: AW])) begin
                        w_fwd_we[i]                = 1'b1;
                        w_fwd_val[i*XLEN +: XLEN]  = lop_done_val;
                    end else begin
                        w_port_haz[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_waw = dec_rd_we && (dec_rd_addr != c_x0) && w_busy[dec_rd_addr] &&
                   !(lop_done && (lop_done_rd == dec_rd_addr));

    assign w_stall = (|w_port_haz) || w_waw || (lop_issue && w_full && !lop_done);

    assign stall     = !rst && w_stall;
    assign fwd_we    = rst ? '0 : w_fwd_we;
    assign fwd_val   = rst ? '0 : w_fwd_val;
    assign sb_full   = w_full;
    assign sb_err    = r_sb_err;
    assign stall_cnt = r_stall_cnt;

    // Scoreboard next-state terms
    logic                 w_done_hit;
    logic                 w_same_rd;
    logic                 w_issue_nz;
    logic                 w_issue_ok;
    logic                 w_issue_new;
    logic                 w_err_now;
    logic [c_num_reg-1:0] w_busy_nxt;

    assign w_done_hit  = lop_done && w_busy[lop_done_rd];
    assign w_same_rd   = lop_issue && lop_done && (lop_issue_rd == lop_done_rd);
    assign w_issue_nz  = lop_issue && (lop_issue_rd != c_x0);
    assign w_issue_ok  = w_issue_nz && (!w_full || w_done_hit);
    // Counter tracks set busy bits, so re-issue to a busy rd does not count twice.
    assign w_issue_new = w_issue_ok && (!w_busy[lop_issue_rd] || (w_same_rd && w_done_hit));

    assign w_err_now =
        (w_issue_nz && w_busy[lop_issue_rd] && !(lop_done && (lop_done_rd == lop_issue_rd))) ||
        (lop_issue && w_full && !lop_done) ||
        (lop_done && !w_busy[lop_done_rd]) ||
        w_same_rd;

    always_comb begin
        w_busy_nxt = w_busy;
        if (lop_done) begin
            w_busy_nxt[lop_done_rd] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_nxt[lop_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_count     <= '0;
            r_sb_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt[c_num_reg-1:1];
            if (w_issue_new && !w_done_hit) begin
                r_count <= r_count + c_one;
            end else if (!w_issue_new && w_done_hit) begin
                r_count <= r_count - c_one;
            end
            if (w_err_now) begin
                r_sb_err <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
// ============================================================================
//  Module      : tb_fwd_hazard_scoreboard
//  Description : Directed self-checking bench for fwd_hazard_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_scoreboard;

    localparam int NUM_RS  = 2;
    localparam int NUM_STG = 2;
    localparam int XLEN    = 32;
    localparam int AW      = 5;
    localparam int MAX_OUT = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_RS*AW-1:0]    rs_addr;
    logic [NUM_RS-1:0]       rs_re;
    logic [NUM_STG*AW-1:0]   stg_rd_addr;
    logic [NUM_STG-1:0]      stg_rd_we;
    logic [NUM_STG-1:0]      stg_rd_rdy;
    logic [NUM_STG*XLEN-1:0] stg_rd_val;
    logic [AW-1:0]           dec_rd_addr;
    logic                    dec_rd_we;
    logic                    lop_issue;
    logic [AW-1:0]           lop_issue_rd;
    logic                    lop_done;
    logic [AW-1:0]           lop_done_rd;
    logic [XLEN-1:0]         lop_done_val;
    logic [NUM_RS*XLEN-1:0]  fwd_val;
    logic [NUM_RS-1:0]       fwd_we;
    logic                    stall;
    logic                    sb_full;
    logic                    sb_err;
    logic [31:0]             stall_cnt;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_scoreboard #(
        .NUM_RS  (NUM_RS),
        .NUM_STG (NUM_STG),
        .XLEN    (XLEN),
        .AW      (AW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_addr      (rs_addr),
        .rs_re        (rs_re),
        .stg_rd_addr  (stg_rd_addr),
        .stg_rd_we    (stg_rd_we),
        .stg_rd_rdy   (stg_rd_rdy),
        .stg_rd_val   (stg_rd_val),
        .dec_rd_addr  (dec_rd_addr),
        .dec_rd_we    (dec_rd_we),
        .lop_issue    (lop_issue),
        .lop_issue_rd (lop_issue_rd),
        .lop_done     (lop_done),
        .lop_done_rd  (lop_done_rd),
        .lop_done_val (lop_done_val),
        .fwd_val      (fwd_val),
        .fwd_we       (fwd_we),
        .stall        (stall),
        .sb_full      (sb_full),
        .sb_err       (sb_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_addr      = '0;
        rs_re        = '0;
        stg_rd_addr  = '0;
        stg_rd_we    = '0;
        stg_rd_rdy   = '0;
        stg_rd_val   = '0;
        dec_rd_addr  = '0;
        dec_rd_we    = 1'b0;
        lop_issue    = 1'b0;
        lop_issue_rd = '0;
        lop_done     = 1'b0;
        lop_done_rd  = '0;
        lop_done_val = '0;
    endtask

    task automatic rd_port(input int p, input logic [AW-1:0] a);
        rs_addr[p*AW +: AW] = a;
        rs_re[p]            = 1'b1;
    endtask

    task automatic test_reset();
        stg_rd_addr = {5'd0, 5'd5};
        stg_rd_we   = 2'b01;
        stg_rd_rdy  = 2'b01;
        stg_rd_val  = {32'h0, 32'h0000_AAAA};
        rd_port(0, 5'd5);
        #1;
        checks++; if (fwd_we !== 2'b00) begin $display("FAIL rst_fwd_we got=%b exp=00", fwd_we); failures++; end
        checks++; if (fwd_val !== 64'h0) begin $display("FAIL rst_fwd_val got=%h exp=0", fwd_val); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL rst_stall got=%b exp=0", stall); failures++; end
        checks++; if (sb_full !== 1'b0 || sb_err !== 1'b0 || stall_cnt !== 32'd0) begin
            $display("FAIL rst_state got full=%b err=%b cnt=%0d exp 0/0/0", sb_full, sb_err, stall_cnt); failures++; end
        idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        idle();
        stg_rd_addr = {5'd5, 5'd5};
        stg_rd_we   = 2'b11;
        stg_rd_rdy  = 2'b11;
        stg_rd_val  = {32'h0000_BBBB, 32'h0000_AAAA};
        rd_port(0, 5'd5);
        #1;
        checks++; if (fwd_we !== 2'b01) begin $display("FAIL prio_we got=%b exp=01", fwd_we); failures++; end
        checks++; if (fwd_val[31:0] !== 32'h0000_AAAA) begin $display("FAIL prio_val got=%h exp=0000aaaa", fwd_val[31:0]); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL prio_stall got=%b exp=0", stall); failures++; end
        stg_rd_addr[4:0] = 5'd6;
        rd_port(1, 5'd6);
        #1;
        checks++; if (fwd_we !== 2'b11) begin $display("FAIL older_we got=%b exp=11", fwd_we); failures++; end
        checks++; if (fwd_val !== 64'h0000_AAAA_0000_BBBB) begin
            $display("FAIL older_val got=%h exp=0000aaaa0000bbbb", fwd_val); failures++; end
        idle();
        tick();
    endtask

    task automatic test_x0_load_use();
        idle();
        stg_rd_addr = {5'd0, 5'd0};
        stg_rd_we   = 2'b01;
        stg_rd_rdy  = 2'b01;
        stg_rd_val  = {32'h0, 32'h0000_5555};
        rd_port(1, 5'd0);
        #1;
        checks++; if (fwd_we !== 2'b00 || fwd_val !== 64'h0) begin
            $display("FAIL x0_fwd got we=%b val=%h exp we=00 val=0", fwd_we, fwd_val); failures++; end
        stg_rd_addr = {5'd7, 5'd7};
        stg_rd_we   = 2'b11;
        stg_rd_rdy  = 2'b10;
        stg_rd_val  = {32'h0000_CCCC, 32'h0000_DDDD};
        rd_port(0, 5'd7);
        #1;
        checks++; if (stall !== 1'b1) begin $display("FAIL load_use_stall got=%b exp=1", stall); failures++; end
        checks++; if (fwd_we !== 2'b00) begin $display("FAIL load_use_no_fallback got=%b exp=00", fwd_we); failures++; end
        rs_re[0] = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL load_use_re0 got=%b exp=0", stall); failures++; end
        rs_re[0] = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (stall_cnt !== 32'd1) begin $display("FAIL stall_cnt_1 got=%0d exp=1", stall_cnt); failures++; end
    endtask

    task automatic test_long_op();
        idle();
        lop_issue    = 1'b1;
        lop_issue_rd = 5'd9;
        tick();
        idle();
        rd_port(0, 5'd9);
        #1;
        checks++; if (stall !== 1'b1 || fwd_we !== 2'b00) begin
            $display("FAIL lop_busy_stall got stall=%b we=%b exp 1/00", stall, fwd_we); failures++; end
        tick();
        lop_done     = 1'b1;
        lop_done_rd  = 5'd9;
        lop_done_val = 32'h0000_1234;
        #1;
        checks++; if (fwd_we !== 2'b01 || fwd_val[31:0] !== 32'h0000_1234) begin
            $display("FAIL lop_bypass got we=%b val=%h exp 01/00001234", fwd_we, fwd_val[31:0]); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL lop_bypass_stall got=%b exp=0", stall); failures++; end
        tick();
        lop_done = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || fwd_we !== 2'b00) begin
            $display("FAIL lop_cleared got stall=%b we=%b exp 0/00", stall, fwd_we); failures++; end
        checks++; if (stall_cnt !== 32'd2 || sb_err !== 1'b0) begin
            $display("FAIL lop_cnt_err got cnt=%0d err=%b exp 2/0", stall_cnt, sb_err); failures++; end
        idle();
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            idle();
            lop_issue    = 1'b1;
            lop_issue_rd = AW'(r);
            tick();
            if (r == 3) begin
                checks++; if (sb_full !== 1'b0) begin $display("FAIL full_at3 got=%b exp=0", sb_full); failures++; end
            end
        end
        checks++; if (sb_full !== 1'b1) begin $display("FAIL full_at4 got=%b exp=1", sb_full); failures++; end
        lop_issue_rd = 5'd5;
        #1;
        checks++; if (stall !== 1'b1) begin $display("FAIL full_issue_stall got=%b exp=1", stall); failures++; end
        lop_done    = 1'b1;
        lop_done_rd = 5'd1;
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL full_issue_done got=%b exp=0", stall); failures++; end
        tick();
        idle();
        #1;
        checks++; if (sb_full !== 1'b1 || sb_err !== 1'b0) begin
            $display("FAIL full_swap got full=%b err=%b exp 1/0", sb_full, sb_err); failures++; end
        rd_port(0, 5'd1);
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL x1_freed got=%b exp=0", stall); failures++; end
        rd_port(0, 5'd5);
        #1;
        checks++; if (stall !== 1'b1) begin $display("FAIL x5_busy got=%b exp=1", stall); failures++; end
        for (int r = 2; r <= 5; r++) begin
            idle();
            lop_done    = 1'b1;
            lop_done_rd = AW'(r);
            tick();
            if (r == 2) begin
                checks++; if (sb_full !== 1'b0) begin $display("FAIL drain_full got=%b exp=0", sb_full); failures++; end
            end
        end
        idle();
        #1;
        checks++; if (sb_err !== 1'b0) begin $display("FAIL drain_err got=%b exp=0", sb_err); failures++; end
    endtask

    task automatic test_waw();
        idle();
        lop_issue    = 1'b1;
        lop_issue_rd = 5'd12;
        tick();
        idle();
        dec_rd_addr = 5'd12;
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL waw_we0 got=%b exp=0", stall); failures++; end
        dec_rd_we = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin $display("FAIL waw_stall got=%b exp=1", stall); failures++; end
        lop_done    = 1'b1;
        lop_done_rd = 5'd12;
        #1;
        checks++; if (stall !== 1'b0) begin $display("FAIL waw_done got=%b exp=0", stall); failures++; end
        tick();
        lop_done = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || sb_err !== 1'b0) begin
            $display("FAIL waw_after got stall=%b err=%b exp 0/0", stall, sb_err); failures++; end
        idle();
    endtask

    task automatic test_errors();
        idle();
        lop_done    = 1'b1;
        lop_done_rd = 5'd20;
        tick();
        idle();
        checks++; if (sb_err !== 1'b1) begin $display("FAIL err_done_idle got=%b exp=1", sb_err); failures++; end
        tick();
        checks++; if (sb_err !== 1'b1) begin $display("FAIL err_sticky got=%b exp=1", sb_err); failures++; end
        lop_issue    = 1'b1;
        lop_issue_rd = 5'd3;
        tick();
        idle();
        checks++; if (stall_cnt !== 32'd2) begin $display("FAIL pre_rst_cnt got=%0d exp=2", stall_cnt); failures++; end
        rst = 1'b1;
        rd_port(0, 5'd3);
        #1;
        checks++; if (stall !== 1'b0 || fwd_we !== 2'b00) begin
            $display("FAIL rst_gate got stall=%b we=%b exp 0/00", stall, fwd_we); failures++; end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (sb_err !== 1'b0 || stall_cnt !== 32'd0 || sb_full !== 1'b0) begin
            $display("FAIL rst_clear got err=%b cnt=%0d full=%b exp 0/0/0", sb_err, stall_cnt, sb_full); failures++; end
        checks++; if (stall !== 1'b0) begin $display("FAIL rst_busy_cleared got=%b exp=0", stall); failures++; end
        idle();
        lop_done    = 1'b1;
        lop_done_rd = 5'd3;
        tick();
        idle();
        checks++; if (sb_err !== 1'b1) begin $display("FAIL late_done_err got=%b exp=1", sb_err); failures++; end
    endtask

    task automatic test_same_rd();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lop_issue    = 1'b1;
        lop_issue_rd = 5'd8;
        tick();
        lop_done    = 1'b1;
        lop_done_rd = 5'd8;
        tick();
        idle();
        rd_port(0, 5'd8);
        #1;
        checks++; if (sb_err !== 1'b1) begin $display("FAIL same_rd_err got=%b exp=1", sb_err); failures++; end
        checks++; if (stall !== 1'b1) begin $display("FAIL same_rd_busy got=%b exp=1", stall); failures++; end
        checks++; if (sb_full !== 1'b0) begin $display("FAIL same_rd_full got=%b exp=0", sb_full); failures++; end
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        test_reset();
        test_priority();
        test_x0_load_use();
        test_long_op();
        test_full();
        test_waw();
        test_errors();
        test_same_rd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the EXE-stage forwarding unit: N read ports, M producer stages with youngest-first priority, x0 suppression and load-use stall detection.
- Adds a registered scoreboard for long-latency writes (multi-cycle loads, mul/div) that complete out of band, with completion bypass and WAW protection.
- Sits between ID_EXE and EXE, driving operand override values and the pipeline stall request.

Parameters:
- NUM_RS, 2, number of source read ports.
- NUM_STG, 2, number of in-pipeline producer stages; index 0 is youngest (EXE_MEM), NUM_STG-1 is oldest (MEM_WB).
- XLEN, `GPR_WIDTH, data width.
- AW, `GPR_ADDR_SPACE, register address width.
- MAX_OUT, 4, maximum outstanding long-latency ops (1..2^AW-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_addr  in  NUM_RS*AW  source addresses; port i at [i*AW +: AW]
- rs_re  in  NUM_RS  source read enables
- stg_rd_addr  in  NUM_STG*AW  producer rd per stage
- stg_rd_we  in  NUM_STG  producer writes rd
- stg_rd_rdy  in  NUM_STG  value valid this cycle; 0 = load still in flight
- stg_rd_val  in  NUM_STG*XLEN  producer value
- dec_rd_addr  in  AW  rd of the instruction in ID_EXE
- dec_rd_we  in  1  instruction in ID_EXE writes rd
- lop_issue  in  1  long op leaves EXE this cycle
- lop_issue_rd  in  AW  its destination
- lop_done  in  1  long op result returns this cycle
- lop_done_rd  in  AW  its destination
- lop_done_val  in  XLEN  its value
- fwd_val  out  NUM_RS*XLEN  forwarded operand per port
- fwd_we  out  NUM_RS  override register-file operand
- stall  out  1  hold ID_EXE and earlier stages
- sb_full  out  1  outstanding count == MAX_OUT
- sb_err  out  1  sticky protocol-violation flag
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
Source resolution (combinational, per port i):
- Hit on stage s: rs_re[i] & stg_rd_we[s] & addr match & rs_addr[i] != 0.
- Select the lowest hit s only. Older stages are never consulted once a younger stage hits.
- If the selected stage has stg_rd_rdy[s] = 1: fwd_we[i] = 1 and fwd_val[i] = that stage's value.
- If the selected stage has stg_rd_rdy[s] = 0: port hazard, fwd_we[i] = 0.
- No stage hit, busy[rs_addr[i]] = 1, and lop_done & lop_done_rd matches: fwd_we[i] = 1 and fwd_val[i] = lop_done_val (same-cycle bypass, no stall).
- No stage hit, busy set, no matching done: port hazard.
- Otherwise fwd_we[i] = 0 and fwd_val[i] = 0.
- A port hazard is ignored when rs_re[i] = 0 or rs_addr[i] = 0.

Stall:
- stall = any port hazard | WAW | (lop_issue & sb_full & ~lop_done).
- WAW = dec_rd_we & dec_rd_addr != 0 & busy[dec_rd_addr] & ~(lop_done & lop_done_rd == dec_rd_addr).

Scoreboard state (registered):
- State is busy[2^AW-1:1] (bit 0 is hardwired 0) and an outstanding counter of width clog2(MAX_OUT+1).
- lop_issue with rd != 0 sets busy[rd]. lop_issue with rd = 0 is accepted but is not tracked.
- lop_done clears busy[lop_done_rd].
- Counter: +1 on a tracked issue, -1 on done, unchanged when both occur in the same cycle.
- Issue and done to the same rd in the same cycle: the result is busy set (the new op owns the register), and sb_err is set.

sb_err is set and held until rst on any of:
- issue to a register that is already busy, excluding same-cycle done on that rd;
- issue while full with no done that cycle (not tracked, counter unchanged);
- done to a register that is not busy (counter unchanged);
- issue and done to the same rd in the same cycle.

stall_cnt:
- +1 on every cycle with stall = 1, saturating at 0xFFFFFFFF.

Reset:
- Synchronous. busy, counter, sb_err and stall_cnt are cleared to 0.
- While rst = 1: stall = 0, fwd_we = 0, fwd_val = 0.
- Reset during outstanding ops discards them; late lop_done after reset sets sb_err.

Latency:
- Forwarding and stall are zero-cycle (same-cycle combinational).
- Scoreboard updates are visible the cycle after the issue/done edge.

Test Plan:
1. Stage 0 holds rd = 5, rdy = 1, val 0xAAAA; stage 1 holds rd = 5, val 0xBBBB; port 0 reads x5 -> fwd_we[0] = 1, fwd_val = 0xAAAA, stall = 0.
2. Port 1 reads x0 while stage 0 writes x0, rdy = 1 -> fwd_we[1] = 0; then stage 0 is a load to x7 with rdy = 0 and port 0 reads x7 -> stall = 1 (no fallback to stage 1 matching x7); stall_cnt = 1 next cycle.
3. Issue long op rd = 9; next cycle port 0 reads x9 -> stall = 1. Cycle 3: lop_done rd = 9, val 0x1234 -> fwd_val = 0x1234, stall = 0. Cycle 4: busy[9] = 0, count = 0.
4. Issue to x1, x2, x3, x4 (MAX_OUT = 4) -> sb_full = 1. A 5th issue with no done -> stall = 1. The same cycle with lop_done on x1 -> no stall, count stays 4.
5. busy[12] = 1, dec_rd = 12, dec_rd_we = 1 -> stall = 1 (WAW). lop_done on x12 -> stall = 0 that cycle.
6. Done to x20 while x20 is not busy -> sb_err = 1 next cycle and held. Assert rst with busy[3] = 1 -> all state 0 next cycle; then lop_done x3 -> sb_err = 1.
